// File: rtl/bomberman_sprite_pkg.sv
// Shared constants and types for the sprite ROM front end.
//   DIM_W      : sprite row/column address width (32x32 sprite)
//   COLOR_W    : RGB444 colour width
//   KEY_COLOR  : sprite background colour, treated as transparent when the
//                SPRITE_TRANSPARENT_KEY_EN build option is enabled
//   arb_state_e: arbiter FSM state (IDLE = no burst owner, HOLD = burst open)
package bomberman_sprite_pkg;

  localparam int DIM_W   = 5;
  localparam int COLOR_W = 12;

  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'h6CC;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage : bomberman_sprite_pkg

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
// Scans the request vector starting at index ptr and wrapping modulo N_REQ,
// and reports the first asserted request.
//   req : request vector
//   ptr : index with highest priority this cycle (must be < N_REQ)
//   gnt : one-hot of the picked request (all zero if none)
//   idx : index of the picked request (0 if none)
//   any : at least one request asserted
module rr_priority_pick #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one 32x32 sprite ROM (registered address,
// one-cycle read) between N_REQ pixel requesters using round-robin
// arbitration with bursts of up to MAX_BURST consecutive grants.
// One lookup is issued per cycle; the colour comes back two cycles after
// the grant, tagged with the requester id.
//
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   req        : per-requester request, held until granted
//   req_row    : packed row addresses, slice i belongs to requester i
//   req_col    : packed column addresses, slice i belongs to requester i
//   gnt        : one-hot grant, combinational, same cycle as acceptance
//   rom_row    : row address to the ROM (holds last value when idle)
//   rom_col    : column address to the ROM (holds last value when idle)
//   rom_data   : ROM colour, valid the cycle after the address
//   rsp_valid  : single-cycle response pulse, two cycles after the grant
//   rsp_id     : requester index of the response
//   rsp_data   : returned colour
//   rsp_opaque : pixel should be drawn
//
// Build option SPRITE_TRANSPARENT_KEY_EN: when defined, rsp_opaque is
// registered with the data and is low for KEY_COLOR pixels. When undefined,
// every returned pixel is opaque (rsp_opaque follows rsp_valid).
module sprite_rom_arbiter #(
  parameter int N_REQ     = 3,
  parameter int DIM_W     = bomberman_sprite_pkg::DIM_W,
  parameter int COLOR_W   = bomberman_sprite_pkg::COLOR_W,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DIM_W-1:0]   req_row,
  input  logic [N_REQ*DIM_W-1:0]   req_col,
  output logic [N_REQ-1:0]         gnt,
  output logic [DIM_W-1:0]         rom_row,
  output logic [DIM_W-1:0]         rom_col,
  input  logic [COLOR_W-1:0]       rom_data,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [COLOR_W-1:0]       rsp_data,
  output logic                     rsp_opaque
);

  import bomberman_sprite_pkg::*;

  localparam logic [3:0] MAX_BURST_L = 4'(MAX_BURST);

  // Arbiter state
  arb_state_e       state_reg, state_next;
  logic [ID_W-1:0]  owner_reg, owner_next;
  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [3:0]       burst_cnt_reg, burst_cnt_next;

  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  logic [N_REQ-1:0] gnt_c;
  logic [ID_W-1:0]  grant_id_c;

  // Address path
  logic [DIM_W-1:0] row_arr [N_REQ];
  logic [DIM_W-1:0] col_arr [N_REQ];
  logic [DIM_W-1:0] row_c, col_c;
  logic [DIM_W-1:0] last_row_reg, last_col_reg;

  // Response pipeline
  logic             s1_valid_reg;
  logic [ID_W-1:0]  s1_id_reg;
  logic             rsp_valid_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic [COLOR_W-1:0] rsp_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign row_arr[gi] = req_row[gi*DIM_W +: DIM_W];
      assign col_arr[gi] = req_col[gi*DIM_W +: DIM_W];
    end
  endgenerate

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and grant. The burst owner keeps the ROM while it requests
  // and has budget left; otherwise a fresh round-robin pick is made in the
  // same cycle so a finished burst never costs an idle slot. The pointer
  // was already advanced past the owner when its burst began, so the owner
  // only wins again if nobody else is asking.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    gnt_c          = '0;
    grant_id_c     = owner_reg;

    if ((state_reg == HOLD) && req[owner_reg] && (burst_cnt_reg < MAX_BURST_L)) begin
      for (int i = 0; i < N_REQ; i++) begin
        gnt_c[i] = (owner_reg == ID_W'(i));
      end
      burst_cnt_next = burst_cnt_reg + 4'd1;
    end else if (pick_any) begin
      gnt_c          = pick_gnt;
      grant_id_c     = pick_idx;
      owner_next     = pick_idx;
      burst_cnt_next = 4'd1;
      state_next     = (MAX_BURST > 1) ? HOLD : IDLE;
      ptr_next       = (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
    end else begin
      state_next     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      ptr_reg       <= ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Grant is forced low while reset is held, even with requests pending.
  assign gnt = reset_n ? gnt_c : '0;

  // AND-OR address mux on the one-hot grant
  always_comb begin
    row_c = '0;
    col_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) begin
        row_c = row_arr[i];
        col_c = col_arr[i];
      end
    end
  end

  // With no grant the ROM address holds its previous value.
  assign rom_row = (|gnt_c) ? row_c : last_row_reg;
  assign rom_col = (|gnt_c) ? col_c : last_col_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_row_reg  <= '0;
      last_col_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      s1_id_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else begin
      if (|gnt_c) begin
        last_row_reg <= row_c;
        last_col_reg <= col_c;
      end
      // Stage 1 tracks the lookup while the ROM performs its read.
      s1_valid_reg  <= |gnt_c;
      s1_id_reg     <= grant_id_c;
      rsp_valid_reg <= s1_valid_reg;
      rsp_id_reg    <= s1_id_reg;
      if (s1_valid_reg) begin
        rsp_data_reg <= rom_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;

`ifdef SPRITE_TRANSPARENT_KEY_EN
  logic rsp_opaque_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_opaque_reg <= 1'b0;
    end else begin
      rsp_opaque_reg <= s1_valid_reg && (rom_data != COLOR_W'(KEY_COLOR));
    end
  end

  assign rsp_opaque = rsp_opaque_reg;
`else
  assign rsp_opaque = rsp_valid_reg;
`endif

endmodule : sprite_rom_arbiter

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one 32x32, 12-bit sprite ROM (registered row/col address, one-cycle read) between N pixel requesters, e.g. player, enemy and bomb renderers.
- Round-robin arbitration with bounded burst hold. Issues one ROM lookup per cycle and returns the colour tagged with the requester id.
- Sits between the per-object pixel generators and the sprite ROM, in the clk domain.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DIM_W, 5, row/col width (32x32 sprite).
- COLOR_W, 12, RGB444 colour width.
- MAX_BURST, 4, maximum consecutive grants to one requester before rotation (1..15).
- ID_W, 2, requester id width; must be ≥ clog2(N_REQ).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request; held until granted.
- req_row  in  N_REQ*DIM_W  packed row addresses; slice i belongs to requester i.
- req_col  in  N_REQ*DIM_W  packed col addresses.
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the accepted request.
- rom_row  out  DIM_W  address to ROM.
- rom_col  out  DIM_W  address to ROM.
- rom_data  in  COLOR_W  ROM colour, valid the cycle after the address is presented.
- rsp_valid  out  1  response valid (registered).
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  COLOR_W  returned colour.
- rsp_opaque  out  1  pixel is not the transparency key (see Optional Feature).

Behaviour:
- Reset:
  - Asserting reset_n = 0 immediately clears rsp_valid, rsp_id, rsp_data, the in-flight stage, the burst counter, the owner register and the rr pointer.
  - After reset: rr pointer = 0, rsp_opaque = 0, gnt = 0 while reset is asserted.
- Handshake: a request is accepted in cycle T iff req[i] & gnt[i]. The requester may change its address or drop req in T+1. Requesters must not drop req before grant.
- Arbitration FSM, states IDLE and HOLD:
  - IDLE: grant the first asserted req[] at or after the rr pointer, wrapping modulo N_REQ. Store owner = i and burst_cnt = 1. Go to HOLD if MAX_BURST > 1. Pointer = i+1 (mod N_REQ).
  - HOLD: if req[owner] = 1 and burst_cnt < MAX_BURST, grant owner again and increment burst_cnt. Otherwise arbitrate as IDLE in the same cycle, so there is no bubble.
  - If no req is asserted, gnt = 0 and the FSM goes to IDLE.
- Datapath timing:
  - T: rom_row/rom_col = selected requester's address (mux on gnt). When idle, they hold their last value.
  - T+1: ROM outputs data; the stage-1 register holds valid and id.
  - T+2: rsp_valid = 1, rsp_id = id, rsp_data = rom_data registered at the end of T+1.
  - Fixed latency 2 from grant to rsp_valid. Throughput 1 lookup/cycle.
  - rsp_valid is a single-cycle pulse per grant. There is no backpressure; consumers must accept.
- Boundaries:
  - N_REQ requesters all continuously requesting get MAX_BURST grants each, in index order from the pointer.
  - Pointer wraps from N_REQ-1 to 0.
  - Address passes through unmodified; 31/31 is legal.
  - A requester re-asserting req one cycle after its burst ended waits for a full rotation if others request.
  - Reset mid-burst or with responses in flight: those responses are never delivered.

Optional Feature:
- Macro SPRITE_TRANSPARENT_KEY_EN.
- Defined: rsp_opaque is registered alongside rsp_data and equals (rom_data != KEY_COLOR), with KEY_COLOR = 12'h6CC, the sprite background colour.
- Undefined: rsp_opaque = rsp_valid, i.e. all returned pixels are drawn, and the comparator is absent.

Decomposition:
- Package bomberman_sprite_pkg: COLOR_W, DIM_W, KEY_COLOR, arbiter state enum (IDLE, HOLD).
- One sub-module, rr_priority_pick: combinational, takes the req vector and the pointer, outputs a one-hot grant and an index.
- Burst/owner FSM and the response pipeline stay in sprite_rom_arbiter.

Test Plan:
- Single requester: req[1] with row=0, col=9 at T -> gnt=3'b010 at T; rom_row/col=0/9; rsp_valid at T+2 with id=1 and data=ROM[0][9] (12'h000).
- All three requesting continuously, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0…; one rsp per cycle, ids in the same order delayed 2 cycles.
- Requester 0 drops req after 2 beats while 2 is pending -> third-cycle grant goes to 2 with no idle cycle; pointer becomes 0 afterwards.
- reset_n pulled low one cycle after a grant -> rsp_valid stays 0, gnt=0. After release, the first request is granted from pointer 0.
- With SPRITE_TRANSPARENT_KEY_EN: lookup of a 12'h6CC pixel -> rsp_opaque=0; lookup of 12'h000 -> rsp_opaque=1. Without the macro, both give rsp_opaque=1.
- Idle bus: no req for 10 cycles -> gnt=0, rsp_valid=0 throughout, rom_row/col unchanged.
